uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Receive side of the SoC UART: recovers 8N1 frames from the asynchronous `uart_rxd_i` pad using 16x oversampling. Received bytes go into a small first-word-fall-through FIFO read through a valid/ready port by the peripheral register layer. It complements the existing UART transmit path and reports sticky framing and overrun errors to software.

## Interface
- `FIFO_DEPTH`, 8, number of receive FIFO entries; must be a power of 2, at least 2.
- `CNT_W`, 4, width of `fifo_count_o`; equals log2(FIFO_DEPTH)+1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `baud_div_i`  in  16  clock cycles per oversample tick; 0 is treated as 1.
- `rx_en_i`  in  1  receiver enable.
- `uart_rxd_i`  in  1  asynchronous serial input; idles high.
- `rx_data_o`  out  8  FIFO head byte; valid while `rx_valid_o` is high.
- `rx_valid_o`  out  1  FIFO not empty.
- `rx_ready_i`  in  1  consumer pop; a pop happens when `rx_valid_o && rx_ready_i`.
- `fifo_count_o`  out  CNT_W  current FIFO occupancy.
- `frame_err_o`  out  1  sticky framing error.
- `overrun_o`  out  1  sticky overrun error.
- `err_clr_i`  in  1  clears both sticky flags.

## Operation
- **Input synchronizer:** 2-flop synchronizer on `uart_rxd_i`; both flops reset to 1. All decoding uses the synchronized bit `rxd_s`.
- **Tick generator:** a counter runs from 0 to max(baud_div_i,1)-1 and emits a 1-cycle `tick` at wrap. It is held at 0 while the FSM is in IDLE and restarts at 0 on entry to START.
- **FSM state IDLE:**
  - `armed` is set when `rxd_s`=1.
  - On `rxd_s`=0 with `armed` and `rx_en_i` high: clear the tick counter, go to START.
- **FSM state START:**
  - At the 8th tick (mid-bit), sample `rxd_s`.
  - Sample 1: false start; go to IDLE with no error.
  - Sample 0: go to DATA with tick count 0 and bit index 0.
- **FSM state DATA:**
  - Every 16th tick, sample `rxd_s` into shift register bit [idx], LSB first.
  - After bit 7, go to STOP.
- **FSM state STOP:** at the 16th tick, sample `rxd_s`.
  - Sample 1: push the byte.
  - Sample 0: discard the byte, set `frame_err_o`, clear `armed`.
  - In both cases, go to IDLE.
- **Disable:** `rx_en_i` low in any state aborts the frame and forces IDLE. FIFO contents and flags are kept.
- **FIFO:**
  - First-word fall-through: `rx_data_o` = mem[rd_ptr].
  - `rx_valid_o` = (count != 0).
  - Pointers wrap modulo FIFO_DEPTH.
- **Push while full:**
  - Without a pop in the same cycle: the byte is dropped, `overrun_o` is set, contents are unchanged.
  - With a pop in the same cycle: the push is accepted and the count is unchanged.
- **Push and pop when not full:** both happen and the count is unchanged.
- **Pop when empty:** ignored.
- **Sticky flags:** `err_clr_i` clears them. If a set event and `err_clr_i` occur in the same cycle, set wins.
- **Reset values:**
  - FSM in IDLE, `armed`=1, counters 0, pointers 0.
  - `fifo_count_o`=0, `rx_valid_o`=0, `rx_data_o`=8'h00 (memory cleared).
  - `frame_err_o`=0, `overrun_o`=0.

## Timing
- Bit period = 16·D cycles, where D = max(`baud_div_i`,1).
- Synchronizer latency: 2 cycles from pad to `rxd_s`.
- Sample points, counted in ticks from START entry:
  - start bit at 8;
  - data bit k at 8+16(k+1);
  - stop bit at 152.
- The push is registered. `rx_valid_o`, `rx_data_o` and `fifo_count_o` update 1 cycle after the stop-sample tick. The flag set timing is the same.
- An in-flight byte is visible on `rx_data_o` the same cycle it becomes head; no extra read latency.
- A new start edge can be accepted in the cycle after the return to IDLE. This allows back-to-back frames with one stop bit.
- `baud_div_i` is sampled live. Changing it mid-frame is undefined; software changes it only while `rx_en_i`=0.
- Reset has priority over every other input in the same cycle. Reset mid-frame returns the block to the reset state and loses the partial byte.

## Test plan
- D=4, `rx_ready_i`=0, send 0xA5 as 8N1 (64 cycles/bit):
  - `rx_valid_o`=1 with `rx_data_o`=0xA5 and `fifo_count_o`=1, about 610 cycles after the falling edge;
  - both flags stay 0.
- D=4, low glitch of 16 cycles on an idle line:
  - no push (false start);
  - the FSM is back in IDLE;
  - a following valid frame of 0x3C is received correctly.
- D=4, send 0x55 with stop bit 0, then line high, then 0x12:
  - `frame_err_o`=1 and 0x55 is not pushed;
  - 0x12 is received;
  - `err_clr_i` pulse makes `frame_err_o`=0.
- D=1, `rx_ready_i`=0, send 0x00..0x08 back-to-back:
  - `fifo_count_o`=8 and `overrun_o`=1;
  - with `rx_ready_i`=1, pops return 0x00..0x07 in order, then `rx_valid_o`=0.
- FIFO full, with `rx_ready_i` held high during the stop-sample push cycle:
  - count stays 8;
  - no overrun;
  - the new byte ends up last in order.
- `rst`=1 for 1 cycle in the middle of DATA bit 4:
  - all outputs return to their reset values;
  - the next full frame, 0xC3, is received correctly.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Receive FIFO read port of the UART receiver: head byte, valid/ready pop
// handshake and occupancy. The core is the master, the register layer the slave.
interface uart_rx_core_if #(
    parameter int CNT_W = 4
);
    logic [7:0]       rx_data_o;
    logic             rx_valid_o;
    logic             rx_ready_i;
    logic [CNT_W-1:0] fifo_count_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output fifo_count_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        input  fifo_count_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver with 16x oversampling, first-word-fall-through receive
// FIFO and sticky framing / overrun flags.
module uart_rx_core #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           baud_div_i,
    input  logic                  rx_en_i,
    input  logic                  uart_rxd_i,
    uart_rx_core_if.master        rx_if,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    input  logic                  err_clr_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic             rxd_meta;
    logic             rxd_s;
    logic             armed;
    logic [15:0]      div_cnt;
    logic [15:0]      div_max;
    logic             tick;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_q;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             stop_sample;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             frame_set;
    logic             overrun_set;

    // NOTE: the synchronizer resets to the idle line level so reset never
    // looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd_i;
            rxd_s    <= rxd_meta;
        end
    end

    assign div_max = (baud_div_i == 16'd0) ? 16'd1 : baud_div_i;
    assign tick    = (state != IDLE) && (div_cnt == div_max - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || tick) begin
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Stop-bit decision is taken on the 16th tick of the stop bit.
    assign stop_sample = (state == STOP) && tick && (tick_cnt == 4'd15) && rx_en_i;
    assign push        = stop_sample && rxd_s;
    assign frame_set   = stop_sample && !rxd_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            armed    <= 1'b1;
            tick_cnt <= 4'd0;
            bit_idx  <= 3'd0;
            shift_q  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    tick_cnt <= 4'd0;
                    if (rxd_s) begin
                        armed <= 1'b1;
                    end else if (armed && rx_en_i) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= 4'd0;
                            bit_idx  <= 3'd0;
                            state    <= rxd_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            shift_q[bit_idx] <= rxd_s;
                            bit_idx          <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            state <= IDLE;
                            if (!rxd_s) begin
                                armed <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Disable aborts any frame in progress; FIFO and flags are untouched.
            if (!rx_en_i) begin
                state    <= IDLE;
                tick_cnt <= 4'd0;
            end
        end
    end

    assign pop         = (count != '0) && rx_if.rx_ready_i;
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign wr_en       = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    // When full, wr_ptr equals rd_ptr; a simultaneous pop frees that slot in
    // the same cycle, so overwriting it keeps the new byte last in order.
    // NOTE: the storage array is reset because software may read rx_data_o
    // right after reset and must see 8'h00.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shift_q;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err_o <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_o <= 1'b0;
            end
            if (overrun_set) begin
                overrun_o <= 1'b1;
            end else if (err_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data_o    = mem[rd_ptr];
    assign rx_if.rx_valid_o   = (count != '0);
    assign rx_if.fifo_count_o = count;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames are driven on the pad and
// the FIFO port and flags are compared against a byte-queue reference model.
module tb_uart_rx_core;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        rx_en;
    logic        uart_rxd;
    logic        err_clr;
    logic        frame_err;
    logic        overrun;

    uart_rx_core_if #(.CNT_W(CW)) rx_if ();

    uart_rx_core #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div_i (baud_div),
        .rx_en_i    (rx_en),
        .uart_rxd_i (uart_rxd),
        .rx_if      (rx_if.master),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   rise_cyc  = 0;
    int   start_cyc = 0;
    logic valid_d   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        valid_d <= rx_if.rx_valid_o;
        if (rx_if.rx_valid_o && !valid_d) rise_cyc <= cyc;
    end

    // Reference model: accepted bytes in arrival order plus the two sticky flags.
    logic [7:0] q[$];
    bit         m_ferr = 1'b0;
    bit         m_ovr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int d);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (16 * d) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(rx_if.fifo_count_o), q.size());
        check({tag, ".valid"}, 32'(rx_if.rx_valid_o), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) check({tag, ".data"}, 32'(rx_if.rx_data_o), 32'(q[0]));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        rx_if.rx_ready_i = 1'b1;
        while (q.size() != 0) begin
            check($sformatf("%s.pop%0d", tag, k), 32'(rx_if.rx_data_o), 32'(q[0]));
            void'(q.pop_front());
            k++;
            @(negedge clk);
        end
        rx_if.rx_ready_i = 1'b0;
        check({tag, ".empty_valid"}, 32'(rx_if.rx_valid_o), 0);
        check({tag, ".empty_count"}, 32'(rx_if.fifo_count_o), 0);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic set_baud(input logic [15:0] d);
        rx_en = 1'b0;
        @(negedge clk);
        baud_div = d;
        @(negedge clk);
        rx_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         lat;
        int         d;

        rst              = 1'b1;
        rx_en            = 1'b1;
        uart_rxd         = 1'b1;
        baud_div         = 16'd4;
        err_clr          = 1'b0;
        rx_if.rx_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset.data", 32'(rx_if.rx_data_o), 0);
        check_state("reset");

        // 0xA5 at D=4, latency from falling edge to rx_valid
        send_frame(8'hA5, 1'b1, 4);
        model_push(8'hA5);
        lat = rise_cyc - start_cyc;
        check("a5.latency_in_window", (lat >= 605 && lat <= 615) ? 1 : 0, 1);
        check_state("a5");
        drain("a5");

        // 16-cycle glitch is a false start, then 0x3C is received
        uart_rxd = 1'b0;
        repeat (16) @(negedge clk);
        idle(200);
        check_state("glitch");
        send_frame(8'h3C, 1'b1, 4);
        model_push(8'h3C);
        check_state("after_glitch");
        drain("3c");

        // Framing error on 0x55, recovery with 0x12, then clear
        send_frame(8'h55, 1'b0, 4);
        idle(128);
        m_ferr = 1'b1;
        check_state("ferr");
        send_frame(8'h12, 1'b1, 4);
        model_push(8'h12);
        check_state("after_ferr");
        clear_flags();
        check_state("ferr_clr");
        drain("12");

        // Random bytes at random divisors with random idle gaps
        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(1, 3);
            set_baud(16'(d));
            b = 8'($urandom);
            send_frame(b, 1'b1, d);
            model_push(b);
            idle($urandom_range(0, 40));
        end
        check_state("rand");
        drain("rand");

        // Nine back-to-back frames at D=1 with no reader: FIFO fills, overrun
        set_baud(16'd1);
        for (int i = 0; i < 9; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, 1);
            model_push(b);
        end
        idle(20);
        check_state("overrun");
        drain("overrun");
        clear_flags();
        check_state("ovr_clr");

        // baud_div 0 acts as 1; push into full FIFO with a pop in the same cycle
        set_baud(16'd0);
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1);
            model_push(b);
        end
        check_state("full");
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1, 1);
            begin
                repeat (154) @(negedge clk);
                rx_if.rx_ready_i = 1'b1;
                @(negedge clk);
                rx_if.rx_ready_i = 1'b0;
                check("full_pop.count", 32'(rx_if.fifo_count_o), DEPTH);
            end
        join
        void'(q.pop_front());
        q.push_back(b);
        idle(10);
        check_state("full_pop");
        drain("full_pop");

        // Reset in the middle of data bit 4 with FIFO content and a flag set
        set_baud(16'd4);
        send_frame(8'h5A, 1'b1, 4);
        model_push(8'h5A);
        send_frame(8'h77, 1'b0, 4);
        idle(128);
        m_ferr = 1'b1;
        check_state("pre_rst");
        b = {4'hF, 4'($urandom)};
        fork
            send_frame(b, 1'b1, 4);
            begin
                repeat (352) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        idle(20);
        check("mid_rst.data", 32'(rx_if.rx_data_o), 0);
        check_state("mid_rst");
        send_frame(8'hC3, 1'b1, 4);
        model_push(8'hC3);
        check_state("c3");
        drain("c3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
